// File: rtl/pong_game_ctrl.sv
// Pong match sequencer.
// Runs the match FSM (IDLE, SERVE, PLAY, POINT, OVER), derives a frame tick
// from the falling edge of vsync, counts serve/point delays in frames, keeps
// both scores, declares the winner and drives the ball datapath controls.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high reset
//   vsync        raw vsync; falling edge is the frame tick
//   start        synchronised start button (level)
//   miss_left    ball left the playfield on the left side (level)
//   miss_right   ball left the playfield on the right side (level)
//   ball_run     enables ball motion updates
//   ball_serve   one-clk pulse: recentre the ball
//   serve_dir    direction of the next serve (1 = toward right player)
//   score_left   left player score
//   score_right  right player score
//   game_state   current FSM state encoding
//   winner       00 none, 01 left, 10 right
//   flash        blink enable for the game-over banner
//
// Optional build macro ATTRACT_MODE_EN: demo play in IDLE (ball runs, a miss
// recentres the ball and flips the serve direction, scores untouched).

module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_run,
  output logic       ball_serve,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [2:0] game_state,
  output logic [1:0] winner,
  output logic       flash
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 8;

  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SCORE_W-1:0] score_left_q, score_left_d;
  logic [SCORE_W-1:0] score_right_q, score_right_d;
  logic [1:0]         winner_q, winner_d;
  logic               serve_dir_q, serve_dir_d;
  logic               vsync_q, start_q;
  logic               serve_pend_q, serve_pend_d;
  logic               ball_serve_q, ball_serve_d;
  logic               ball_run_q, ball_run_d;
  logic               flash_q, flash_d;

  logic tick;
  logic start_p;
  logic any_miss;

  assign tick     = vsync_q & ~vsync;
  assign start_p  = start & ~start_q;
  assign any_miss = miss_left | miss_right;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= '0;
      score_left_q  <= '0;
      score_right_q <= '0;
      winner_q      <= 2'b00;
      serve_dir_q   <= 1'b1;
      vsync_q       <= 1'b1;
      start_q       <= 1'b1;
      serve_pend_q  <= 1'b0;
      ball_serve_q  <= 1'b0;
      ball_run_q    <= 1'b0;
      flash_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      winner_q      <= winner_d;
      serve_dir_q   <= serve_dir_d;
      vsync_q       <= vsync;
      start_q       <= start;
      serve_pend_q  <= serve_pend_d;
      ball_serve_q  <= ball_serve_d;
      ball_run_q    <= ball_run_d;
      flash_q       <= flash_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;
    serve_pend_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          state_d       = ST_SERVE;
          score_left_d  = '0;
          score_right_d = '0;
          winner_d      = 2'b00;
        end
`ifdef ATTRACT_MODE_EN
        else if (tick && any_miss) begin
          serve_pend_d = 1'b1;
          serve_dir_d  = ~serve_dir_q;
        end
`endif
      end

      ST_SERVE: begin
        if (tick && (frame_cnt_q == SERVE_LAST)) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // Misses are levels; sampling only on the tick gives one point per miss
        if (tick && any_miss) begin
          state_d = ST_POINT;
          if (miss_left && !miss_right) begin
            if (score_right_q < WIN_S) score_right_d = score_right_q + SCORE_W'(1);
            serve_dir_d = 1'b0;
          end else if (miss_right && !miss_left) begin
            if (score_left_q < WIN_S) score_left_d = score_left_q + SCORE_W'(1);
            serve_dir_d = 1'b1;
          end
        end
      end

      ST_POINT: begin
        if (tick && (frame_cnt_q == POINT_LAST)) begin
          if (score_left_q == WIN_S) begin
            state_d  = ST_OVER;
            winner_d = 2'b01;
          end else if (score_right_q == WIN_S) begin
            state_d  = ST_OVER;
            winner_d = 2'b10;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end

      ST_OVER: begin
        if (start_p) begin
          state_d       = ST_SERVE;
          score_left_d  = '0;
          score_right_d = '0;
          winner_d      = 2'b00;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Recentre request on SERVE entry; the pulse itself lags one more clk
    if ((state_d == ST_SERVE) && (state_q != ST_SERVE)) begin
      serve_pend_d = 1'b1;
    end
    ball_serve_d = serve_pend_q;

    frame_cnt_d = (state_d != state_q) ? '0 : frame_cnt_q + CNT_W'(tick);

`ifdef ATTRACT_MODE_EN
    ball_run_d = (state_q == ST_PLAY) || (state_q == ST_IDLE);
`else
    ball_run_d = (state_q == ST_PLAY);
`endif

    // Computed from next values so flash tracks frame_cnt[4] without lag
    flash_d = (state_d == ST_OVER) && frame_cnt_d[4];
  end

  assign ball_run    = ball_run_q;
  assign ball_serve  = ball_serve_q;
  assign serve_dir   = serve_dir_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign game_state  = state_q;
  assign winner      = winner_q;
  assign flash       = flash_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed match walk-through with literal
// expectations, then randomized play checked every cycle against a
// behavioural model of the match rules.

module tb_pong_game_ctrl;

  localparam int WIN   = 2;
  localparam int SERVE = 3;
  localparam int POINT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       start = 1'b1;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_run, ball_serve, serve_dir, flash;
  logic [3:0] score_left, score_right;
  logic [2:0] game_state;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pong_game_ctrl #(
    .WIN_SCORE   (WIN),
    .SERVE_FRAMES(SERVE),
    .POINT_FRAMES(POINT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .start      (start),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .ball_run   (ball_run),
    .ball_serve (ball_serve),
    .serve_dir  (serve_dir),
    .score_left (score_left),
    .score_right(score_right),
    .game_state (game_state),
    .winner     (winner),
    .flash      (flash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: states 0 idle, 1 serve, 2 play, 3 point, 4 over
  int m_st = 0, m_frames = 0, m_sl = 0, m_sr = 0, m_win = 0, m_dir = 1;
  int m_run = 0, m_serve = 0, m_flash = 0, m_next = 0;
  bit m_recentre = 0, m_last_vs = 1, m_last_start = 1, m_tick = 0, m_press = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_st = 0; m_frames = 0; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1;
      m_run = 0; m_serve = 0; m_flash = 0; m_recentre = 0;
      m_last_vs = 1; m_last_start = 1;
    end else begin
      m_tick  = m_last_vs && !vsync;
      m_press = start && !m_last_start;
      m_last_vs = vsync;
      m_last_start = start;
      m_next = m_st;
      m_serve = m_recentre;
      m_recentre = 0;
`ifdef ATTRACT_MODE_EN
      m_run = (m_st == 2 || m_st == 0);
`else
      m_run = (m_st == 2);
`endif
      if (m_st == 0 || m_st == 4) begin
        if (m_press) begin
          m_next = 1; m_sl = 0; m_sr = 0; m_win = 0;
        end
`ifdef ATTRACT_MODE_EN
        else if (m_st == 0 && m_tick && (miss_left || miss_right)) begin
          m_recentre = 1;
          m_dir = 1 - m_dir;
        end
`endif
      end else if (m_st == 1) begin
        if (m_tick && m_frames + 1 == SERVE) m_next = 2;
      end else if (m_st == 2) begin
        if (m_tick && (miss_left || miss_right)) begin
          m_next = 3;
          if (miss_left && !miss_right) begin
            m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1;
            m_dir = 0;
          end
          if (miss_right && !miss_left) begin
            m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1;
            m_dir = 1;
          end
        end
      end else if (m_st == 3) begin
        if (m_tick && m_frames + 1 == POINT) begin
          if (m_sl == WIN)      begin m_next = 4; m_win = 1; end
          else if (m_sr == WIN) begin m_next = 4; m_win = 2; end
          else                  m_next = 1;
        end
      end else begin
        m_next = 0;
      end
      if (m_next == 1 && m_st != 1) m_recentre = 1;
      m_frames = (m_next != m_st) ? 0 : (m_frames + int'(m_tick)) % 256;
      m_st = m_next;
      m_flash = (m_st == 4 && ((m_frames / 16) % 2) == 1) ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",       int'(game_state),  m_st);
      chk("score_left",  int'(score_left),  m_sl);
      chk("score_right", int'(score_right), m_sr);
      chk("winner",      int'(winner),      m_win);
      chk("serve_dir",   int'(serve_dir),   m_dir);
      chk("ball_run",    int'(ball_run),    m_run);
      chk("ball_serve",  int'(ball_serve),  m_serve);
      chk("flash",       int'(flash),       m_flash);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vsync = 1'b1; cyc(3);
    vsync = 1'b0; cyc(3);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press();
    start = 1'b0; cyc(2);
    start = 1'b1; cyc(2);
  endtask

  initial begin
    // Reset with vsync low and start held
    reset = 1'b1; vsync = 1'b0; start = 1'b1;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    chk("lit_idle_state", int'(game_state), 0);
    chk("lit_idle_score", int'(score_left) + int'(score_right), 0);
    chk("lit_idle_serve", int'(ball_serve), 0);
    chk("lit_idle_dir",   int'(serve_dir), 1);

    // Release and re-press start: SERVE entry, then serve pulse one clk later
    start = 1'b0; cyc(2);
    start = 1'b1; cyc(1);
    chk("lit_serve_state", int'(game_state), 1);
    chk("lit_serve_pulse0", int'(ball_serve), 0);
    cyc(1);
    chk("lit_serve_pulse1", int'(ball_serve), 1);
    cyc(1);
    chk("lit_serve_pulse2", int'(ball_serve), 0);

    frames(3);
    chk("lit_play_state", int'(game_state), 2);
    chk("lit_play_run",   int'(ball_run), 1);

    // Held miss_left across ticks: single point to the right player
    miss_left = 1'b1; frames(2); miss_left = 1'b0;
    chk("lit_missl_state", int'(game_state), 3);
    chk("lit_missl_sr",    int'(score_right), 1);
    chk("lit_missl_dir",   int'(serve_dir), 0);
    frames(1);
    frames(3);

    // Simultaneous misses: no score change
    miss_left = 1'b1; miss_right = 1'b1; frames(1);
    miss_left = 1'b0; miss_right = 1'b0;
    chk("lit_both_state", int'(game_state), 3);
    chk("lit_both_sl",    int'(score_left), 0);
    chk("lit_both_sr",    int'(score_right), 1);
    frames(2);
    chk("lit_both_serve", int'(game_state), 1);
    frames(3);

    // Two right misses: left wins
    miss_right = 1'b1; frames(1); miss_right = 1'b0;
    frames(2); frames(3);
    miss_right = 1'b1; frames(1); miss_right = 1'b0;
    frames(2);
    chk("lit_over_state",  int'(game_state), 4);
    chk("lit_over_winner", int'(winner), 1);
    chk("lit_over_sl",     int'(score_left), 2);
    frames(20);
    chk("lit_flash_on", int'(flash), 1);
    frames(14);
    chk("lit_flash_off", int'(flash), 0);

    press();
    chk("lit_restart_state",  int'(game_state), 1);
    chk("lit_restart_score",  int'(score_left) + int'(score_right), 0);
    chk("lit_restart_winner", int'(winner), 0);

    // Reset mid-PLAY on a tick edge
    frames(3);
    vsync = 1'b1; cyc(3);
    vsync = 1'b0; reset = 1'b1; cyc(1);
    chk("lit_rst_state", int'(game_state), 0);
    chk("lit_rst_run",   int'(ball_run), 0);
    chk("lit_rst_score", int'(score_left) + int'(score_right), 0);
    reset = 1'b0;

    // Randomized play
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 3) == 0)  vsync = ~vsync;
      if ($urandom_range(0, 39) == 0) start = ~start;
      if ($urandom_range(0, 11) == 0) miss_left = ~miss_left;
      if ($urandom_range(0, 11) == 0) miss_right = ~miss_right;
    end
    reset = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
